// File: rtl/keypad_decoder.sv
// keypad_decoder
//   Scans a 6x4 active-low matrix keypad, synchronises and debounces the column
//   returns, and emits exactly one single-cycle key event per debounced press for
//   the calculator register stage.
//
//   Key map (row r, column c; the lowest-numbered low column wins):
//     rows 0-3 : hex key, value 4*r+c  -> newhex / hexcode
//     row  4   : operator, opcode = c  -> newop  / opcode
//     row  5   : c0 = equals -> eq ; c1-c3 ignored (no pulse, key_busy still toggles)
//
//   Ports
//     clock       in   1  system clock
//     reset       in   1  synchronous, active-high
//     col_n       in   4  column returns, active-low, asynchronous, pulled up
//     row_n       out  6  row drive, active-low, exactly one bit low
//     newhex      out  1  one-cycle pulse: hex key event
//     hexcode     out  4  value of the last hex key, held between events
//     newop       out  1  one-cycle pulse: operator key event
//     opcode      out  2  operator of the last operator key, held between events
//     eq          out  1  one-cycle pulse: equals key event
//     key_busy    out  1  high from press detection until release is debounced
//     dbg_state_o out  2  current FSM state (SCAN=0, PRESS=1, EMIT=2, RELEASE=3)
//
//   Handshake: there is none; every event output is a fire-and-forget pulse that
//   is valid for exactly the one cycle it is high, with no back-pressure.
//
//   Build option: define KEYPAD_REPEAT_EN to make held hex keys auto-repeat
//   (first repeat REPEAT_DELAY cycles after the first pulse, then every
//   REPEAT_PERIOD cycles). Without it, REPEAT_DELAY/REPEAT_PERIOD are unused.
module keypad_decoder #(
    parameter int unsigned SETTLE_CYCLES   = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] col_n,
    output logic [5:0] row_n,
    output logic       newhex,
    output logic [3:0] hexcode,
    output logic       newop,
    output logic [1:0] opcode,
    output logic       eq,
    output logic       key_busy,
    output logic [1:0] dbg_state_o
);

    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ?
                                      SETTLE_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNT_W = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SCAN    = 2'd0,
        ST_PRESS   = 2'd1,
        ST_EMIT    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       row_q, row_d;
    logic [1:0]       col_q, col_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       sync1_q, sync2_q;
    logic [3:0]       hexcode_q, hexcode_d;
    logic [1:0]       opcode_q, opcode_d;

    logic       any_low;
    logic [1:0] low_col;
    logic [2:0] next_row;
    logic       is_hex, is_op, is_eq;
    logic       emit_hex, emit_op, emit_eq;
    logic       rep_pulse;

    // Priority encode: the lowest low column wins.
    always_comb begin
        any_low = ~&sync2_q;
        low_col = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (!sync2_q[c]) low_col = 2'(c);
        end
    end

    assign next_row = (row_q == 3'd5) ? 3'd0 : row_q + 3'd1;

    // The row stays driven from capture to release, so row_q is the key's row.
    assign is_hex = (row_q < 3'd4);
    assign is_op  = (row_q == 3'd4);
    assign is_eq  = (row_q == 3'd5) && (col_q == 2'd0);

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        cnt_d     = cnt_q;
        hexcode_d = hexcode_q;
        opcode_d  = opcode_q;
        emit_hex  = 1'b0;
        emit_op   = 1'b0;
        emit_eq   = 1'b0;
        case (state_q)
            ST_SCAN: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d = '0;
                    if (any_low) begin
                        col_d   = low_col;
                        state_d = ST_PRESS;
                    end else begin
                        row_d = next_row;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PRESS: begin
                if (!sync2_q[col_q]) begin
                    if (cnt_q == DEB_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_EMIT;
                        // Codes load on entry to EMIT so they are valid with the pulse.
                        if (is_hex) hexcode_d = {row_q[1:0], col_q};
                        if (is_op)  opcode_d  = col_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_EMIT: begin
                emit_hex = is_hex;
                emit_op  = is_op;
                emit_eq  = is_eq;
                cnt_d    = '0;
                state_d  = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (sync2_q == 4'hF) begin
                    if (cnt_q == DEB_LAST) begin
                        cnt_d   = '0;
                        row_d   = next_row;
                        state_d = ST_SCAN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_SCAN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_SCAN;
            row_q     <= 3'd0;
            col_q     <= 2'd0;
            cnt_q     <= '0;
            sync1_q   <= 4'hF;
            sync2_q   <= 4'hF;
            hexcode_q <= 4'h0;
            opcode_q  <= 2'd0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            cnt_q     <= cnt_d;
            sync1_q   <= col_n;
            sync2_q   <= sync1_q;
            hexcode_q <= hexcode_d;
            opcode_q  <= opcode_d;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                                      REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W = $clog2(REP_MAX);
    localparam logic [REP_W-1:0] RD_LAST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] RP_LAST = REP_W'(REPEAT_PERIOD - 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_first_q, rep_first_d;
    logic             rep_arm_q, rep_arm_d;

    // Repeat timing counts RELEASE cycles from the first pulse; any cycle with the
    // captured column high disarms it until the next press.
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        rep_arm_d   = rep_arm_q;
        rep_pulse   = 1'b0;
        if (state_q == ST_EMIT) begin
            rep_cnt_d   = '0;
            rep_first_d = 1'b1;
            rep_arm_d   = is_hex;
        end else if (state_q == ST_RELEASE) begin
            if (sync2_q[col_q]) begin
                rep_arm_d = 1'b0;
            end else if (rep_arm_q) begin
                if (rep_cnt_q == (rep_first_q ? RD_LAST : RP_LAST)) begin
                    rep_pulse   = 1'b1;
                    rep_cnt_d   = '0;
                    rep_first_d = 1'b0;
                end else begin
                    rep_cnt_d = rep_cnt_q + REP_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b0;
            rep_arm_q   <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
            rep_arm_q   <= rep_arm_d;
        end
    end
`else
    assign rep_pulse = 1'b0;
`endif

    assign row_n       = ~(6'b000001 << row_q);
    assign newhex      = emit_hex | rep_pulse;
    assign newop       = emit_op;
    assign eq          = emit_eq;
    assign hexcode     = hexcode_q;
    assign opcode      = opcode_q;
    assign key_busy    = (state_q != ST_SCAN);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_keypad_decoder.sv
// Testbench for keypad_decoder: a keypad matrix model drives col_n from row_n and
// the set of pressed keys; a scoreboard holds the events each press must produce.
module tb_keypad_decoder;

    localparam int SETTLE = 4;
    localparam int DEB    = 8;
    localparam int RD     = 40;
    localparam int RP     = 10;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] col_n;
    logic [5:0] row_n;
    logic       newhex, newop, eq, key_busy;
    logic [3:0] hexcode;
    logic [1:0] opcode;
    logic [1:0] dbg_state;

    logic [23:0] pressed = '0;   // bit 4*r+c: key at row r, column c held down

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    // Event encoding: [7:6] kind (1 hex, 2 op, 3 eq), [3:0] code.
    logic [7:0] exp_q[$];

    keypad_decoder #(
        .SETTLE_CYCLES  (SETTLE),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .col_n      (col_n),
        .row_n      (row_n),
        .newhex     (newhex),
        .hexcode    (hexcode),
        .newop      (newop),
        .opcode     (opcode),
        .eq         (eq),
        .key_busy   (key_busy),
        .dbg_state_o(dbg_state)
    );

    // ---- clock / reset block ----
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Keypad matrix: a held key pulls its column low while its row is driven low.
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference key map.
    function automatic logic [7:0] key_event(input int r, input int c);
        if (r < 4)                return {2'd1, 2'd0, 4'(4*r + c)};
        else if (r == 4)          return {2'd2, 4'd0, 2'(c)};
        else if (r == 5 && c == 0) return {2'd3, 6'd0};
        else                      return 8'h00;
    endfunction

    // ---- scoreboard / monitor ----
    logic       busy_prev = 1'b0;
    logic       first_pending = 1'b0;
    int         busy_rise = 0;
    logic [3:0] model_hex = 4'h0;
    logic [1:0] model_op = 2'd0;

    always @(negedge clock) begin
        logic [7:0] obs, e;
        cyc++;
        if (reset) begin
            busy_prev     = 1'b0;
            first_pending = 1'b0;
            model_hex     = 4'h0;
            model_op      = 2'd0;
        end else begin
            check("row_one_low", 32'($countones(~row_n)), 32'd1);
            if (key_busy && !busy_prev) begin
                busy_rise     = cyc;
                first_pending = 1'b1;
            end
            busy_prev = key_busy;
            if (newhex || newop || eq) begin
                check("one_pulse", 32'(int'(newhex) + int'(newop) + int'(eq)), 32'd1);
                obs = newhex ? {2'd1, 2'd0, hexcode} :
                      newop  ? {2'd2, 4'd0, opcode}  : {2'd3, 6'd0};
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 32'(obs), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("event", 32'(obs), 32'(e));
                    if (e[7:6] == 2'd1) model_hex = e[3:0];
                    if (e[7:6] == 2'd2) model_op  = e[1:0];
                end
                if (first_pending) begin
                    check("latency", 32'(cyc - busy_rise), 32'(DEB));
                    first_pending = 1'b0;
                end
            end
            check("hexcode_hold", 32'(hexcode), 32'(model_hex));
            check("opcode_hold", 32'(opcode), 32'(model_op));
        end
    end

    // ---- driver tasks ----
    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_busy(input logic lvl, input int budget);
        int k = 0;
        while (key_busy !== lvl && k < budget) begin
            @(negedge clock);
            k++;
        end
        check("busy_wait", 32'(key_busy), 32'(lvl));
        cycles(1);
    endtask

    // Press a mask of columns on one row, hold past debounce, release, settle.
    task automatic press_row(input int r, input logic [3:0] mask, input int extra);
        int lo = 0;
        logic [7:0] ev;
        for (int c = 3; c >= 0; c--) if (mask[c]) lo = c;
        ev = key_event(r, lo);
        if (ev != 8'h00) exp_q.push_back(ev);
        pressed[r*4 +: 4] = mask;
        wait_busy(1'b1, 200);
        cycles(DEB + 2 + extra);
        pressed = '0;
        wait_busy(1'b0, 100);
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // ---- stimulus ----
    initial begin
        reset = 1'b1;
        cycles(3);
        check("rst_row_n", 32'(row_n), 32'h3E);
        check("rst_busy", 32'(key_busy), 32'd0);
        check("rst_pulses", 32'({newhex, newop, eq}), 32'd0);
        check("rst_hexcode", 32'(hexcode), 32'd0);
        check("rst_opcode", 32'(opcode), 32'd0);
        reset = 1'b0;
        cycles(2);

        // Long hold of r1c2: one hex 6.
        press_row(1, 4'b0100, 50);

        // Bounce r3c3, then hold stable: single hex F.
        exp_q.push_back(key_event(3, 3));
        for (int i = 0; i < 10; i++) begin
            pressed[15] = ~pressed[15];
            cycles(3);
        end
        pressed[15] = 1'b1;
        cycles(60);
        pressed = '0;
        wait_busy(1'b0, 100);
        check("bounce_drain", 32'(exp_q.size()), 32'd0);

        // Operator, equals, ignored key.
        press_row(4, 4'b1000, 5);
        press_row(5, 4'b0001, 5);
        press_row(5, 4'b0100, 5);

        // Short release while held does not re-trigger; a full release does.
        exp_q.push_back(key_event(0, 1));
        pressed[1] = 1'b1;
        wait_busy(1'b1, 200);
        cycles(DEB + 10);
        pressed = '0;
        cycles(5);
        pressed[1] = 1'b1;
        cycles(30);
        check("busy_held", 32'(key_busy), 32'd1);
        check("no_repress", 32'(exp_q.size()), 32'd0);
        pressed = '0;
        cycles(20);
        press_row(0, 4'b0010, 5);

        // A second key on another row while one is held is ignored.
        exp_q.push_back(key_event(0, 0));
        pressed[0] = 1'b1;
        wait_busy(1'b1, 200);
        cycles(DEB + 4);
        pressed[14] = 1'b1;
        cycles(20);
        pressed = '0;
        wait_busy(1'b0, 100);
        cycles(60);
        check("second_key_drain", 32'(exp_q.size()), 32'd0);

        // Reset during PRESS aborts the event.
        pressed[8] = 1'b1;
        wait_busy(1'b1, 200);
        cycles(3);
        reset   = 1'b1;
        pressed = '0;
        cycles(1);
        check("abort_row_n", 32'(row_n), 32'h3E);
        check("abort_busy", 32'(key_busy), 32'd0);
        reset = 1'b0;
        cycles(60);
        check("abort_drain", 32'(exp_q.size()), 32'd0);

`ifdef KEYPAD_REPEAT_EN
        // Held hex key repeats; operator does not.
        for (int i = 0; i < 3; i++) exp_q.push_back(key_event(2, 2));
        pressed[10] = 1'b1;
        wait_busy(1'b1, 200);
        cycles(DEB + RD + RP + 4);
        pressed = '0;
        wait_busy(1'b0, 100);
        check("repeat_drain", 32'(exp_q.size()), 32'd0);
        exp_q.push_back(key_event(4, 0));
        pressed[16] = 1'b1;
        wait_busy(1'b1, 200);
        cycles(DEB + RD + RP + 4);
        pressed = '0;
        wait_busy(1'b0, 100);
        check("op_norepeat_drain", 32'(exp_q.size()), 32'd0);
`endif

        // Randomised presses with optional short glitches.
        for (int it = 0; it < 40; it++) begin
            int r;
            logic [3:0] mask;
            if ($urandom_range(0, 3) == 0) begin
                pressed[$urandom_range(0, 23)] = 1'b1;
                cycles($urandom_range(1, 3));
                pressed = '0;
                cycles(20);
                wait_busy(1'b0, 50);
            end
            r    = $urandom_range(0, 5);
            mask = 4'b0001 << $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) mask = mask | (4'b0001 << $urandom_range(0, 3));
            press_row(r, mask, $urandom_range(0, 20));
        end

        cycles(10);
        check("final_drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
